// File: rtl/prefetch_queue_if.sv
// Memory-side bus between the prefetch unit and the shared arbiter.
// The prefetch unit is the master (issues requests); the arbiter is the slave.
interface prefetch_queue_if #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned INSTR_W = 32
);
  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_cack;
  logic               mem_ready;
  logic [INSTR_W-1:0] mem_data;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_cack,
    input  mem_ready,
    input  mem_data
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_cack,
    output mem_ready,
    output mem_data
  );
endinterface

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: fetches sequential words from the arbiter into a
// DEPTH-entry FIFO, one request outstanding at a time. A redirect flushes the
// FIFO and restarts fetch; a response already in flight is discarded.

// Companion checker: a push must never land on a full FIFO, because a slot is
// reserved before every request is issued.
module prefetch_queue_chk #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 3
) (
  input logic          clk,
  input logic          rst,
  input logic          push,
  input logic          pop,
  input logic [CW-1:0] count
);
  no_overflow_a: assert property (@(posedge clk) disable iff (!rst)
    push |-> ((count < CW'(DEPTH)) || pop));
endmodule

module prefetch_queue #(
  parameter int unsigned       ADDR_W     = 16,
  parameter int unsigned       INSTR_W    = 32,
  parameter int unsigned       DEPTH      = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = {ADDR_W{1'b0}}
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fetch_en,
  input  logic                   redirect,
  input  logic [ADDR_W-1:0]      redirect_addr,
  input  logic                   instr_take,
  output logic                   instr_valid,
  output logic [INSTR_W-1:0]     instr_out,
  output logic [ADDR_W-1:0]      instr_addr,
  output logic [$clog2(DEPTH):0] queue_level,
  prefetch_queue_if.master       mem
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT    = 2'd2,
    DISCARD = 2'd3
  } state_t;

  state_t             state;
  logic               req;
  logic [ADDR_W-1:0]  fetch_pc;
  logic [PW-1:0]      rd_ptr;
  logic [PW-1:0]      wr_ptr;
  logic [CW-1:0]      count;
  logic [ADDR_W-1:0]  fifo_addr [DEPTH];
  logic [INSTR_W-1:0] fifo_data [DEPTH];

  logic               pop;
  logic               push;
  logic [CW:0]        level_after;
  logic               issue_ok;
  logic [CW-1:0]      count_next;
  logic [PW-1:0]      rd_next;
  logic [PW-1:0]      wr_next;
  logic [ADDR_W-1:0]  head_addr_next;
  logic [INSTR_W-1:0] head_data_next;

  assign instr_valid  = (count != {CW{1'b0}});
  assign queue_level  = count;
  assign mem.mem_req  = req;
  assign mem.mem_addr = fetch_pc;

  // Push/pop decode, slot reservation and next FIFO bookkeeping; redirect wins over all.
  always_comb begin
    pop  = instr_take & instr_valid & ~redirect;
    push = 1'b0;
    if (redirect) begin
      push = 1'b0;
    end else if (state == REQ) begin
      push = mem.mem_cack & mem.mem_ready;
    end else if (state == WAIT) begin
      push = mem.mem_ready;
    end else begin
      push = 1'b0;
    end

    level_after = {1'b0, count} + (CW+1)'(push) - (CW+1)'(pop);
    issue_ok    = fetch_en & ~redirect & (level_after < (CW+1)'(DEPTH));

    if (redirect) begin
      count_next = {CW{1'b0}};
      rd_next    = {PW{1'b0}};
      wr_next    = {PW{1'b0}};
    end else begin
      count_next = level_after[CW-1:0];
      rd_next    = rd_ptr + PW'(pop);
      wr_next    = wr_ptr + PW'(push);
    end

    // The head register tracks whatever entry sits at the read pointer next cycle;
    // a push into an (effectively) empty FIFO goes straight to the head.
    head_addr_next = instr_addr;
    head_data_next = instr_out;
    if (redirect) begin
      head_addr_next = instr_addr;
      head_data_next = instr_out;
    end else if (push && (count == CW'(pop))) begin
      head_addr_next = fetch_pc;
      head_data_next = mem.mem_data;
    end else if (pop) begin
      head_addr_next = fifo_addr[rd_next];
      head_data_next = fifo_data[rd_next];
    end else begin
      head_addr_next = instr_addr;
      head_data_next = instr_out;
    end
  end

  // Fetch FSM with registered request strobe and fetch address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      req      <= 1'b0;
      fetch_pc <= RESET_ADDR;
    end else begin
      if (redirect) begin
        fetch_pc <= redirect_addr;
      end else if (push) begin
        fetch_pc <= fetch_pc + ADDR_W'(1'b1);
      end

      case (state)
        IDLE: begin
          if (issue_ok) begin
            state <= REQ;
            req   <= 1'b1;
          end
        end
        REQ: begin
          if (mem.mem_cack && mem.mem_ready) begin
            state <= IDLE;
            req   <= 1'b0;
          end else if (mem.mem_cack) begin
            state <= redirect ? DISCARD : WAIT;
            req   <= 1'b0;
          end else begin
            state <= REQ;
            req   <= 1'b1;
          end
        end
        WAIT: begin
          if (mem.mem_ready) begin
            state <= IDLE;
          end else if (redirect) begin
            state <= DISCARD;
          end
          req <= 1'b0;
        end
        DISCARD: begin
          if (mem.mem_ready) begin
            state <= IDLE;
          end
          req <= 1'b0;
        end
        default: begin
          state <= IDLE;
          req   <= 1'b0;
        end
      endcase
    end
  end

  // FIFO pointers, occupancy and registered head entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr     <= {PW{1'b0}};
      wr_ptr     <= {PW{1'b0}};
      count      <= {CW{1'b0}};
      instr_addr <= {ADDR_W{1'b0}};
      instr_out  <= {INSTR_W{1'b0}};
    end else begin
      rd_ptr     <= rd_next;
      wr_ptr     <= wr_next;
      count      <= count_next;
      instr_addr <= head_addr_next;
      instr_out  <= head_data_next;
    end
  end

  // FIFO storage; contents need no reset since occupancy gates their use.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= fetch_pc;
      fifo_data[wr_ptr] <= mem.mem_data;
    end
  end

  prefetch_queue_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .count (count)
  );

endmodule
